// File: rtl/skin_bbox_detect.sv
// Skin-tone classifier on a YCbCr stream: emits a binarised video stream and, once per
// frame, the bounding box and pixel count of the skin region seen in that frame.
module skin_bbox_detect #(
   parameter int CB_MIN  = 77,
   parameter int CB_MAX  = 127,
   parameter int CR_MIN  = 133,
   parameter int CR_MAX  = 173,
   parameter int MIN_PIX = 64,
   parameter int CW      = 11
) (
   input  logic          pixelclk,
   input  logic          rst_n,
   input  logic [23:0]   i_ycbcr,
   input  logic          i_hsync,
   input  logic          i_vsync,
   input  logic          i_de,
   output logic [23:0]   o_bin,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_de,
   output logic          o_box_valid,
   output logic          o_box_hit,
   output logic [CW-1:0] o_xmin,
   output logic [CW-1:0] o_xmax,
   output logic [CW-1:0] o_ymin,
   output logic [CW-1:0] o_ymax,
   output logic [20:0]   o_pix_cnt
);

   localparam logic [CW-1:0] COORD_MAX = '1;
   localparam logic [20:0]   COUNT_MAX = '1;

   logic [7:0]    cb;
   logic [7:0]    cr;
   logic          skin;
   logic          vs_rise;
   logic          de_fall;
   logic          frame_seen;
   logic [CW-1:0] x_cnt;
   logic [CW-1:0] y_cnt;
   logic [CW-1:0] xmin;
   logic [CW-1:0] xmax;
   logic [CW-1:0] ymin;
   logic [CW-1:0] ymax;
   logic [20:0]   count;

   assign cb = i_ycbcr[15:8];
   assign cr = i_ycbcr[7:0];
   assign skin = i_de && (cb >= 8'(CB_MIN)) && (cb <= 8'(CB_MAX))
                      && (cr >= 8'(CR_MIN)) && (cr <= 8'(CR_MAX));
   // o_vsync/o_de double as the one-cycle-delayed copies used for edge detection
   assign vs_rise = i_vsync & ~o_vsync;
   assign de_fall = o_de & ~i_de;

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         o_bin   <= '0;
         o_hsync <= 1'b0;
         o_vsync <= 1'b0;
         o_de    <= 1'b0;
      end else begin
         o_bin   <= skin ? 24'hFFFFFF : 24'h000000;
         o_hsync <= i_hsync;
         o_vsync <= i_vsync;
         o_de    <= i_de;
      end
   end

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (vs_rise) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (i_de) begin
         if (x_cnt != COORD_MAX) x_cnt <= x_cnt + 1'b1;
      end else if (de_fall) begin
         x_cnt <= '0;
         if (y_cnt != COORD_MAX) y_cnt <= y_cnt + 1'b1;
      end
   end

   // Frame end takes priority, so a skin pixel landing on vs_rise is never accumulated
   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         xmin  <= '1;
         xmax  <= '0;
         ymin  <= '1;
         ymax  <= '0;
         count <= '0;
      end else if (vs_rise) begin
         xmin  <= '1;
         xmax  <= '0;
         ymin  <= '1;
         ymax  <= '0;
         count <= '0;
      end else if (skin) begin
         if (x_cnt < xmin) xmin <= x_cnt;
         if (x_cnt > xmax) xmax <= x_cnt;
         if (y_cnt < ymin) ymin <= y_cnt;
         if (y_cnt > ymax) ymax <= y_cnt;
         if (count != COUNT_MAX) count <= count + 1'b1;
      end
   end

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_seen  <= 1'b0;
         o_box_valid <= 1'b0;
         o_box_hit   <= 1'b0;
         o_xmin      <= '0;
         o_xmax      <= '0;
         o_ymin      <= '0;
         o_ymax      <= '0;
         o_pix_cnt   <= '0;
      end else begin
         o_box_valid <= vs_rise & frame_seen;
         if (vs_rise) begin
            frame_seen <= 1'b1;
            // The frame in progress at reset is partial, so its results are dropped
            if (frame_seen) begin
               o_pix_cnt <= count;
               if (count >= 21'(MIN_PIX)) begin
                  o_box_hit <= 1'b1;
                  o_xmin    <= xmin;
                  o_xmax    <= xmax;
                  o_ymin    <= ymin;
                  o_ymax    <= ymax;
               end else begin
                  o_box_hit <= 1'b0;
                  o_xmin    <= '0;
                  o_xmax    <= '0;
                  o_ymin    <= '0;
                  o_ymax    <= '0;
               end
            end
         end
      end
   end

endmodule
